// File: rtl/hsv_core_issue_dispatch_if.sv
// Issue-side, commit-side and per-unit dispatch signals of hsv_core_issue_dispatch.
// The slave modport is the dispatcher; the master modport is decode/commit/units.
interface hsv_core_issue_dispatch_if #(
  parameter int NUM_UNITS = 5,
  parameter int PAYLOAD_W = 64,
  parameter int NUM_REGS  = 32,
  parameter int TOKEN_W   = 3
);
  localparam int AW = $clog2(NUM_REGS);

  logic                           flush_req;
  logic                           valid_i;
  logic                           ready_o;
  logic [NUM_UNITS-1:0]           select_i;
  logic [PAYLOAD_W-1:0]           payload_i;
  logic [AW-1:0]                  rs1_addr_i;
  logic [AW-1:0]                  rs2_addr_i;
  logic                           rs1_used_i;
  logic                           rs2_used_i;
  logic [AW-1:0]                  rd_addr_i;
  logic                           rd_we_i;
  logic [AW-1:0]                  rs1_addr_o;
  logic [AW-1:0]                  rs2_addr_o;
  logic [31:0]                    rs1_data_i;
  logic [31:0]                    rs2_data_i;
  logic                           commit_valid_i;
  logic [AW-1:0]                  commit_rd_addr_i;
  logic [31:0]                    commit_data_i;
  logic [NUM_UNITS-1:0]           unit_valid_o;
  logic [NUM_UNITS-1:0]           unit_ready_i;
  logic [NUM_UNITS*PAYLOAD_W-1:0] unit_payload_o;
  logic [NUM_UNITS*32-1:0]        unit_rs1_o;
  logic [NUM_UNITS*32-1:0]        unit_rs2_o;
  logic [NUM_UNITS*AW-1:0]        unit_rd_o;
  logic [NUM_UNITS*TOKEN_W-1:0]   unit_token_o;
  logic                           hazard_o;

  modport slave (
    input  flush_req, valid_i, select_i, payload_i, rs1_addr_i, rs2_addr_i,
           rs1_used_i, rs2_used_i, rd_addr_i, rd_we_i, rs1_data_i, rs2_data_i,
           commit_valid_i, commit_rd_addr_i, commit_data_i, unit_ready_i,
    output ready_o, rs1_addr_o, rs2_addr_o, unit_valid_o, unit_payload_o,
           unit_rs1_o, unit_rs2_o, unit_rd_o, unit_token_o, hazard_o
  );

  modport master (
    output flush_req, valid_i, select_i, payload_i, rs1_addr_i, rs2_addr_i,
           rs1_used_i, rs2_used_i, rd_addr_i, rd_we_i, rs1_data_i, rs2_data_i,
           commit_valid_i, commit_rd_addr_i, commit_data_i, unit_ready_i,
    input  ready_o, rs1_addr_o, rs2_addr_o, unit_valid_o, unit_payload_o,
           unit_rs1_o, unit_rs2_o, unit_rd_o, unit_token_o, hazard_o
  );
endinterface

// File: rtl/hsv_core_issue_dispatch.sv
// Issue dispatcher with counting scoreboard and per-unit registered output slots.
// Optional commit-to-operand bypass: define HSV_ISSUE_COMMIT_BYPASS_EN.
module hsv_core_issue_dispatch #(
  parameter int NUM_UNITS = 5,
  parameter int PAYLOAD_W = 64,
  parameter int NUM_REGS  = 32,
  parameter int TOKEN_W   = 3,
  parameter int PEND_W    = 2
) (
  input  logic                     clk_core,
  input  logic                     rst_core_n,
  hsv_core_issue_dispatch_if.slave io
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NUM_REGS-1:0][PEND_W-1:0] pend;
  logic [NUM_UNITS-1:0] slot_valid;
  logic [NUM_UNITS-1:0] slot_free;
  logic [TOKEN_W-1:0]   token_q, token_d;
  logic rs1_pend, rs2_pend, rs1_byp, rs2_byp, rs1_haz, rs2_haz, rd_haz;
  logic hazard, sel_onehot, sel_free, ready, accept;
  logic [31:0] op1, op2;

  assign io.rs1_addr_o   = io.rs1_addr_i;
  assign io.rs2_addr_o   = io.rs2_addr_i;
  assign io.unit_valid_o = slot_valid;
  assign io.hazard_o     = hazard;
  assign io.ready_o      = ready;
  assign slot_free       = ~slot_valid | io.unit_ready_i;

  always_comb begin
    rs1_pend = io.rs1_used_i && (io.rs1_addr_i != '0) && (pend[io.rs1_addr_i] != '0);
    rs2_pend = io.rs2_used_i && (io.rs2_addr_i != '0) && (pend[io.rs2_addr_i] != '0);
`ifdef HSV_ISSUE_COMMIT_BYPASS_EN
    // The last outstanding write retiring this cycle supplies the operand directly.
    rs1_byp = rs1_pend && (pend[io.rs1_addr_i] == PEND_W'(1)) && io.commit_valid_i
              && (io.commit_rd_addr_i == io.rs1_addr_i);
    rs2_byp = rs2_pend && (pend[io.rs2_addr_i] == PEND_W'(1)) && io.commit_valid_i
              && (io.commit_rd_addr_i == io.rs2_addr_i);
    op1 = rs1_byp ? io.commit_data_i : io.rs1_data_i;
    op2 = rs2_byp ? io.commit_data_i : io.rs2_data_i;
`else
    rs1_byp = 1'b0;
    rs2_byp = 1'b0;
    op1     = io.rs1_data_i;
    op2     = io.rs2_data_i;
`endif
    rs1_haz    = rs1_pend && !rs1_byp;
    rs2_haz    = rs2_pend && !rs2_byp;
    rd_haz     = io.rd_we_i && (io.rd_addr_i != '0) && (pend[io.rd_addr_i] == PEND_MAX);
    hazard     = io.valid_i && (rs1_haz || rs2_haz || rd_haz);
    sel_onehot = (io.select_i != '0)
                 && ((io.select_i & (io.select_i - NUM_UNITS'(1))) == '0);
    sel_free   = |(io.select_i & slot_free);
    ready      = !io.flush_req && !hazard && sel_onehot && sel_free;
    accept     = io.valid_i && ready;
    token_d    = token_q;
    if (io.flush_req)  token_d = '0;
    else if (accept)   token_d = token_q + TOKEN_W'(1);
  end

`ifndef HSV_ISSUE_COMMIT_BYPASS_EN
  logic unused_commit_data;
  assign unused_commit_data = ^io.commit_data_i;
`endif

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) token_q <= '0;
    else             token_q <= token_d;
  end

  // Outstanding-write counters; x0 is never incremented or decremented.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic inc, dec;
    always_comb begin
      inc   = accept && io.rd_we_i && (io.rd_addr_i == AW'(gi)) && (gi != 0);
      dec   = io.commit_valid_i && (io.commit_rd_addr_i == AW'(gi)) && (gi != 0)
              && (cnt_q != '0);
      cnt_d = cnt_q;
      if (io.flush_req)     cnt_d = '0;
      else if (inc && !dec) cnt_d = cnt_q + PEND_W'(1);
      else if (dec && !inc) cnt_d = cnt_q - PEND_W'(1);
    end
    always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) cnt_q <= '0;
      else             cnt_q <= cnt_d;
    end
    assign pend[gi] = cnt_q;
  end

  // Independent output slots: a stalled unit only holds its own slot.
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slot
    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [31:0]          rs1_q, rs1_d, rs2_q, rs2_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [TOKEN_W-1:0]   tok_q, tok_d;
    always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      tok_d     = tok_q;
      if (io.flush_req) begin
        valid_d = 1'b0;
      end else if (accept && io.select_i[gi]) begin
        valid_d   = 1'b1;
        payload_d = io.payload_i;
        rs1_d     = op1;
        rs2_d     = op2;
        rd_d      = io.rd_addr_i;
        tok_d     = token_q;
      end else if (io.unit_ready_i[gi]) begin
        valid_d = 1'b0;
      end
    end
    always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
        valid_q   <= 1'b0;
        payload_q <= '0;
        rs1_q     <= '0;
        rs2_q     <= '0;
        rd_q      <= '0;
        tok_q     <= '0;
      end else begin
        valid_q   <= valid_d;
        payload_q <= payload_d;
        rs1_q     <= rs1_d;
        rs2_q     <= rs2_d;
        rd_q      <= rd_d;
        tok_q     <= tok_d;
      end
    end
    assign slot_valid[gi]                                = valid_q;
    assign io.unit_payload_o[gi*PAYLOAD_W +: PAYLOAD_W]  = payload_q;
    assign io.unit_rs1_o[gi*32 +: 32]                    = rs1_q;
    assign io.unit_rs2_o[gi*32 +: 32]                    = rs2_q;
    assign io.unit_rd_o[gi*AW +: AW]                     = rd_q;
    assign io.unit_token_o[gi*TOKEN_W +: TOKEN_W]        = tok_q;
  end
endmodule

// File: tb/tb_hsv_core_issue_dispatch.sv
// Self-checking bench for hsv_core_issue_dispatch: directed vector table, token-wrap
// sequence and randomized traffic checked against a scoreboard-level reference model.
module tb_hsv_core_issue_dispatch;
  localparam int NU = 5;
  localparam int PW = 64;
  localparam int NR = 32;
  localparam int TW = 3;
  localparam int AW = 5;
  localparam int PMAX = 3;
`ifdef HSV_ISSUE_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hsv_core_issue_dispatch_if #(.NUM_UNITS(NU), .PAYLOAD_W(PW), .NUM_REGS(NR), .TOKEN_W(TW)) io();
  hsv_core_issue_dispatch #(.NUM_UNITS(NU), .PAYLOAD_W(PW), .NUM_REGS(NR), .TOKEN_W(TW),
                            .PEND_W(2)) dut (.clk_core(clk), .rst_core_n(rst_n), .io(io));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_valid [NU];
  logic [63:0] m_pay   [NU];
  logic [31:0] m_rs1   [NU];
  logic [31:0] m_rs2   [NU];
  int          m_rd    [NU];
  int          m_tok   [NU];
  int          m_token;
  int          m_pend  [NR];

  typedef struct {
    bit v; bit fl; logic [NU-1:0] sel; bit r1u; int r1; bit we; int rd;
    bit cv; int crd; logic [NU-1:0] ur; bit e_rdy; bit e_haz; logic [NU-1:0] e_uv;
  } vec_t;
  vec_t tab[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_src_haz(input bit used, input int a);
    if (!used || a == 0 || m_pend[a] == 0) return 1'b0;
    if (BYP && m_pend[a] == 1 && io.commit_valid_i && int'(io.commit_rd_addr_i) == a)
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_operand(input bit used, input int a, input logic [31:0] rf);
    if (BYP && used && a != 0 && m_pend[a] == 1 && io.commit_valid_i
        && int'(io.commit_rd_addr_i) == a) return io.commit_data_i;
    return rf;
  endfunction

  task automatic clear_in();
    io.flush_req = 0; io.valid_i = 0; io.select_i = '0; io.payload_i = '0;
    io.rs1_addr_i = '0; io.rs2_addr_i = '0; io.rs1_used_i = 0; io.rs2_used_i = 0;
    io.rd_addr_i = '0; io.rd_we_i = 0; io.rs1_data_i = '0; io.rs2_data_i = '0;
    io.commit_valid_i = 0; io.commit_rd_addr_i = '0; io.commit_data_i = '0;
    io.unit_ready_i = '1;
  endtask

  task automatic rand_data();
    io.payload_i     = {$urandom, $urandom};
    io.rs1_data_i    = $urandom;
    io.rs2_data_i    = $urandom;
    io.commit_data_i = $urandom;
  endtask

  task automatic check_slots();
    logic [NU-1:0] ev;
    for (int j = 0; j < NU; j++) ev[j] = m_valid[j];
    chk("unit_valid", 64'(io.unit_valid_o), 64'(ev));
    for (int j = 0; j < NU; j++) begin
      if (m_valid[j]) begin
        chk($sformatf("slot%0d_payload", j), io.unit_payload_o[j*PW +: PW], m_pay[j]);
        chk($sformatf("slot%0d_rs1", j), 64'(io.unit_rs1_o[j*32 +: 32]), 64'(m_rs1[j]));
        chk($sformatf("slot%0d_rs2", j), 64'(io.unit_rs2_o[j*32 +: 32]), 64'(m_rs2[j]));
        chk($sformatf("slot%0d_rd", j), 64'(io.unit_rd_o[j*AW +: AW]), 64'(m_rd[j]));
        chk($sformatf("slot%0d_token", j), 64'(io.unit_token_o[j*TW +: TW]), 64'(m_tok[j]));
      end
    end
  endtask

  // Inputs are already applied; check combinational outputs, step model, clock, check slots.
  task automatic run_cycle(input bit use_tab, input bit t_rdy, input bit t_haz,
                           input logic [NU-1:0] t_uv);
    bit e_haz, e_rdy, acc;
    int k, r1, r2, rd, crd;
    int old [NR];
    logic [31:0] o1, o2;
    #1;
    r1 = int'(io.rs1_addr_i); r2 = int'(io.rs2_addr_i);
    rd = int'(io.rd_addr_i);  crd = int'(io.commit_rd_addr_i);
    e_haz = io.valid_i && (m_src_haz(io.rs1_used_i, r1) || m_src_haz(io.rs2_used_i, r2)
            || (io.rd_we_i && rd != 0 && m_pend[rd] == PMAX));
    k = -1;
    if ($countones(io.select_i) == 1)
      for (int j = 0; j < NU; j++) if (io.select_i[j]) k = j;
    e_rdy = !io.flush_req && !e_haz && (k >= 0) && (k < 0 ? 1'b0 : (!m_valid[k] || io.unit_ready_i[k]));
    chk("hazard_o", 64'(io.hazard_o), 64'(e_haz));
    chk("ready_o", 64'(io.ready_o), 64'(e_rdy));
    chk("rs_addr_o", 64'({io.rs1_addr_o, io.rs2_addr_o}), 64'({io.rs1_addr_i, io.rs2_addr_i}));
    if (use_tab) begin
      chk("tab_ready_o", 64'(io.ready_o), 64'(t_rdy));
      chk("tab_hazard_o", 64'(io.hazard_o), 64'(t_haz));
    end
    acc = io.valid_i && e_rdy;
    o1 = m_operand(io.rs1_used_i, r1, io.rs1_data_i);
    o2 = m_operand(io.rs2_used_i, r2, io.rs2_data_i);
    if (io.flush_req) begin
      for (int j = 0; j < NU; j++) m_valid[j] = 0;
      for (int j = 0; j < NR; j++) m_pend[j] = 0;
      m_token = 0;
    end else begin
      for (int j = 0; j < NU; j++) if (m_valid[j] && io.unit_ready_i[j]) m_valid[j] = 0;
      if (acc) begin
        m_valid[k] = 1; m_pay[k] = io.payload_i; m_rs1[k] = o1; m_rs2[k] = o2;
        m_rd[k] = rd; m_tok[k] = m_token;
        $display("issue t=%0t slot=%0d token=%0d rd=%0d we=%0b", $time, k, m_token, rd, io.rd_we_i);
        m_token = (m_token + 1) % (1 << TW);
      end
      old = m_pend;
      if (acc && io.rd_we_i && rd != 0) m_pend[rd]++;
      if (io.commit_valid_i && crd != 0 && old[crd] != 0) m_pend[crd]--;
    end
    @(posedge clk);
    #1;
    check_slots();
    if (use_tab) chk("tab_unit_valid", 64'(io.unit_valid_o), 64'(t_uv));
  endtask

  function automatic vec_t mk(bit v, bit fl, logic [NU-1:0] sel, bit r1u, int r1, bit we, int rd,
                              bit cv, int crd, logic [NU-1:0] ur, bit e_rdy, bit e_haz,
                              logic [NU-1:0] e_uv);
    vec_t t;
    t.v = v; t.fl = fl; t.sel = sel; t.r1u = r1u; t.r1 = r1; t.we = we; t.rd = rd;
    t.cv = cv; t.crd = crd; t.ur = ur; t.e_rdy = e_rdy; t.e_haz = e_haz; t.e_uv = e_uv;
    return t;
  endfunction

  initial begin
    logic [NU-1:0] by_uv;
    clear_in();
    m_token = 0;
    for (int j = 0; j < NU; j++) begin m_valid[j] = 0; m_tok[j] = 0; end
    for (int j = 0; j < NR; j++) m_pend[j] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_unit_valid", 64'(io.unit_valid_o), 64'd0);
    chk("rst_unit_token", 64'(io.unit_token_o), 64'd0);
    chk("rst_unit_payload0", io.unit_payload_o[63:0], 64'd0);
    chk("rst_unit_rs1", 64'(io.unit_rs1_o[63:0]), 64'd0);
    chk("rst_unit_rd", 64'(io.unit_rd_o), 64'd0);
    rst_n = 1'b1;

    by_uv = BYP ? 5'b00011 : 5'b00001;
    //            v fl sel      r1u r1 we rd cv crd ur       rdy   haz   uv
    tab.push_back(mk(1, 0, 5'b00001, 1, 0, 1, 5, 0, 0, 5'b11111, 1,    0,    5'b00001));
    tab.push_back(mk(1, 0, 5'b00010, 1, 5, 1, 6, 0, 0, 5'b00000, 0,    1,    5'b00001));
    tab.push_back(mk(1, 0, 5'b00010, 1, 5, 1, 6, 1, 5, 5'b00000, BYP,  !BYP, by_uv));
    tab.push_back(mk(1, 0, 5'b00010, 1, 5, 1, 6, 0, 0, 5'b00000, !BYP, 0,    5'b00011));
    tab.push_back(mk(1, 0, 5'b00010, 0, 0, 0, 0, 0, 0, 5'b00000, 0,    0,    5'b00011));
    tab.push_back(mk(1, 0, 5'b00100, 0, 0, 0, 0, 0, 0, 5'b00000, 1,    0,    5'b00111));
    tab.push_back(mk(0, 0, 5'b00001, 0, 0, 0, 0, 0, 0, 5'b11111, 1,    0,    5'b00000));
    tab.push_back(mk(1, 0, 5'b00001, 0, 0, 1, 7, 0, 0, 5'b11111, 1,    0,    5'b00001));
    tab.push_back(mk(1, 0, 5'b00010, 0, 0, 1, 7, 0, 0, 5'b11111, 1,    0,    5'b00010));
    tab.push_back(mk(1, 0, 5'b00100, 0, 0, 1, 7, 0, 0, 5'b11111, 1,    0,    5'b00100));
    tab.push_back(mk(1, 0, 5'b01000, 0, 0, 1, 7, 0, 0, 5'b11111, 0,    1,    5'b00000));
    tab.push_back(mk(1, 0, 5'b01000, 0, 0, 1, 7, 1, 7, 5'b11111, 0,    1,    5'b00000));
    tab.push_back(mk(1, 0, 5'b01000, 0, 0, 1, 7, 0, 0, 5'b11111, 1,    0,    5'b01000));
    tab.push_back(mk(1, 0, 5'b00001, 0, 0, 1, 3, 0, 0, 5'b00000, 1,    0,    5'b01001));
    tab.push_back(mk(1, 0, 5'b00010, 0, 0, 1, 3, 0, 0, 5'b00000, 1,    0,    5'b01011));
    tab.push_back(mk(1, 1, 5'b00100, 0, 0, 1, 3, 1, 6, 5'b00000, 0,    0,    5'b00000));
    tab.push_back(mk(1, 0, 5'b00001, 1, 3, 1, 7, 0, 0, 5'b11111, 1,    0,    5'b00001));
    tab.push_back(mk(1, 0, 5'b00010, 1, 7, 0, 0, 0, 0, 5'b11111, 0,    1,    5'b00000));
    tab.push_back(mk(0, 0, 5'b00000, 0, 0, 0, 0, 0, 0, 5'b11111, 0,    0,    5'b00000));
    tab.push_back(mk(1, 0, 5'b00011, 0, 0, 0, 0, 0, 0, 5'b11111, 0,    0,    5'b00000));
    tab.push_back(mk(1, 0, 5'b00001, 1, 6, 1, 0, 1, 9, 5'b11111, 1,    0,    5'b00001));
    tab.push_back(mk(1, 0, 5'b00010, 1, 9, 1, 9, 0, 0, 5'b11111, 1,    0,    5'b00010));

    for (int i = 0; i < tab.size(); i++) begin
      clear_in();
      rand_data();
      if (i == 0) io.rs1_data_i = 32'h10;
      io.valid_i = tab[i].v; io.flush_req = tab[i].fl; io.select_i = tab[i].sel;
      io.rs1_used_i = tab[i].r1u; io.rs1_addr_i = AW'(tab[i].r1);
      io.rd_we_i = tab[i].we; io.rd_addr_i = AW'(tab[i].rd);
      io.commit_valid_i = tab[i].cv; io.commit_rd_addr_i = AW'(tab[i].crd);
      io.unit_ready_i = tab[i].ur;
      run_cycle(1'b1, tab[i].e_rdy, tab[i].e_haz, tab[i].e_uv);
      if (i == 0) chk("first_issue_rs1", 64'(io.unit_rs1_o[31:0]), 64'h10);
    end

    // Token wrap: flush, then nine issues rotating over the slots
    clear_in();
    io.flush_req = 1;
    run_cycle(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 9; i++) begin
      clear_in();
      rand_data();
      io.valid_i = 1;
      io.select_i = NU'(1 << (i % NU));
      run_cycle(1'b0, 1'b0, 1'b0, '0);
      chk($sformatf("token_wrap_%0d", i), 64'(io.unit_token_o[(i % NU)*TW +: TW]), 64'(i % 8));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      clear_in();
      rand_data();
      io.valid_i          = ($urandom_range(0, 3) != 0);
      io.flush_req        = ($urandom_range(0, 49) == 0);
      io.select_i         = ($urandom_range(0, 9) == 0) ? NU'($urandom) : NU'(1 << $urandom_range(0, NU-1));
      io.rs1_used_i       = $urandom_range(0, 1);
      io.rs2_used_i       = $urandom_range(0, 1);
      io.rs1_addr_i       = AW'($urandom_range(0, 7));
      io.rs2_addr_i       = AW'($urandom_range(0, 7));
      io.rd_we_i          = $urandom_range(0, 1);
      io.rd_addr_i        = AW'($urandom_range(0, 7));
      io.commit_valid_i   = $urandom_range(0, 1);
      io.commit_rd_addr_i = AW'($urandom_range(0, 7));
      io.unit_ready_i     = NU'($urandom) | NU'($urandom);
      run_cycle(1'b0, 1'b0, 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
